// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port synchronous RAM between two masters.
// Registers the RAM command at grant and routes read data back two cycles later.
module ram_arbiter #(
    parameter int unsigned AW        = 8,
    parameter int unsigned DW        = 64,
    parameter int unsigned PRIO_MODE = 0
) (
    input  logic          clk,
    input  logic          reset_n,

    input  logic          m0_req,
    input  logic          m0_wr,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,

    input  logic          m1_req,
    input  logic          m1_wr,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,

    output logic          ram_cen,
    output logic          ram_wen,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    typedef enum logic {
        REQ_M0 = 1'b0,
        REQ_M1 = 1'b1
    } req_id_e;

    typedef struct packed {
        logic    v;
        logic    rd;
        req_id_e id;
    } tag_t;

    localparam tag_t TAG_IDLE = '{v: 1'b0, rd: 1'b0, id: REQ_M0};

    req_id_e       last_gnt_q, last_gnt_d;
    logic          cen_q, cen_d;
    logic          wen_q, wen_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] din_q, din_d;
    tag_t          s1_q, s1_d;
    tag_t          s2_q, s2_d;
    logic          rvalid0_q, rvalid0_d;
    logic          rvalid1_q, rvalid1_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;

    logic          gnt0, gnt1, xfer;
    req_id_e       win_id;
    logic          win_wr;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;

    // last_gnt resets to m1 so that m0 wins the first conflict
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (m0_req && m1_req) begin
            if ((PRIO_MODE == 1) || (last_gnt_q == REQ_M1)) begin
                gnt0 = 1'b1;
            end else begin
                gnt1 = 1'b1;
            end
        end else begin
            gnt0 = m0_req;
            gnt1 = m1_req;
        end
    end

    always_comb begin
        xfer      = gnt0 | gnt1;
        win_id    = gnt1 ? REQ_M1   : REQ_M0;
        win_wr    = gnt1 ? m1_wr    : m0_wr;
        win_addr  = gnt1 ? m1_addr  : m0_addr;
        win_wdata = gnt1 ? m1_wdata : m0_wdata;
    end

    always_comb begin
        last_gnt_d = last_gnt_q;
        cen_d      = 1'b0;
        wen_d      = 1'b0;
        addr_d     = addr_q;
        din_d      = din_q;
        s1_d       = TAG_IDLE;
        if (xfer) begin
            last_gnt_d = win_id;
            cen_d      = 1'b1;
            wen_d      = win_wr;
            addr_d     = win_addr;
            din_d      = win_wdata;
            s1_d.v     = 1'b1;
            s1_d.rd    = ~win_wr;
            s1_d.id    = win_id;
        end
    end

    // S2 marks the cycle in which ram_dout carries the read issued two edges earlier
    always_comb begin
        s2_d      = s1_q;
        rvalid0_d = s2_q.v && s2_q.rd && (s2_q.id == REQ_M0);
        rvalid1_d = s2_q.v && s2_q.rd && (s2_q.id == REQ_M1);
        rdata0_d  = rvalid0_d ? ram_dout : rdata0_q;
        rdata1_d  = rvalid1_d ? ram_dout : rdata1_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_gnt_q <= REQ_M1;
            cen_q      <= 1'b0;
            wen_q      <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
            s1_q       <= TAG_IDLE;
            s2_q       <= TAG_IDLE;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            last_gnt_q <= last_gnt_d;
            cen_q      <= cen_d;
            wen_q      <= wen_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

    assign m0_gnt    = gnt0;
    assign m1_gnt    = gnt1;
    assign m0_rvalid = rvalid0_q;
    assign m1_rvalid = rvalid1_q;
    assign m0_rdata  = rdata0_q;
    assign m1_rdata  = rdata1_q;
    assign ram_cen   = cen_q;
    assign ram_wen   = wen_q;
    assign ram_addr  = addr_q;
    assign ram_din   = din_q;

endmodule
